seg_scan_display: RTL and testbench

- Parametrised successor to the team's 4-digit seven-segment display driver: NUM_DIGITS digits, configurable scan rate and anti-ghost dead time.
- Adds:
  - frame-synchronous double-buffered input load, so there is no tearing;
  - per-digit blink;
  - leading-zero suppression.
- Sits between core/game logic and the board AN/SEGMENT pins.
- Drives active-low anodes and segments, matching the existing board wiring.

---
 rtl/seg_display_pkg.sv | 24 ++
 rtl/seg_hex_decoder.sv | 18 +
 rtl/seg_scan_display.sv | 180 ++++++++++++++++++
 tb/tb_seg_scan_display.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display.
package seg_display_pkg;

  // Hex font, active-high, bit 0 = segment a, bit 6 = segment g.
  // Index 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0 (lowercase b and d).
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Every segment and the point off, in active-low form.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Ceiling log2, never below 1, so it can size any counter directly.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Nibble + point to an active-low {p,g,f,e,d,c,b,a} pattern, with separate
// darkening of the seven segments and of the decimal point.
module seg_hex_decoder
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       point,
  input  logic       darkSegs,
  input  logic       darkPoint,
  output logic [7:0] segN
);

  logic [6:0] glyph;

  assign glyph = HEX_FONT[nibble] & {7{~darkSegs}};
  assign segN  = {~(point & ~darkPoint), ~glyph};

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed N-digit seven-segment scanner with dead time, frame-synchronous
// double buffering, per-digit blink and leading-zero suppression.
module seg_scan_display
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 131072,
  parameter int DEAD_CYC     = 64,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] hexs,
  input  logic [NUM_DIGITS-1:0]   points,
  input  logic [NUM_DIGITS-1:0]   LEs,
  input  logic [NUM_DIGITS-1:0]   blinks,
  input  logic                    lz_en,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [7:0]              SEGMENT,
  output logic                    frame_start
);

  localparam int SLOT_W = clog2(SCAN_DIV);
  localparam int IDX_W  = clog2(NUM_DIGITS);
  localparam int FRM_W  = clog2(BLINK_FRAMES);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] DEAD_END  = SLOT_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  // Scan state
  logic [SLOT_W-1:0] slotCntReg;
  logic [IDX_W-1:0]  idxReg;
  logic [FRM_W-1:0]  frameCntReg;
  logic              blinkPhaseReg;

  // Pending (written by load) and display (swapped at frame start) buffers
  logic [4*NUM_DIGITS-1:0] pendHexReg, dispHexReg;
  logic [NUM_DIGITS-1:0]   pendPointReg, dispPointReg;
  logic [NUM_DIGITS-1:0]   pendLeReg, dispLeReg;
  logic [NUM_DIGITS-1:0]   pendBlinkReg, dispBlinkReg;
  logic                    pendValidReg;

  // Registered outputs
  logic [NUM_DIGITS-1:0] anReg;
  logic [7:0]            segReg;
  logic                  frameStartReg;

  logic                    slotWrap;
  logic                    frameStartNow;
  logic                    swapNow;
  logic                    phaseCur;
  logic [4*NUM_DIGITS-1:0] dispHexCur;
  logic [NUM_DIGITS-1:0]   dispPointCur, dispLeCur, dispBlinkCur;
  logic [NUM_DIGITS-1:0]   zeroFrom;
  logic [7:0]              segPattern [NUM_DIGITS];

  assign slotWrap      = (slotCntReg == SLOT_LAST);
  assign frameStartNow = (slotCntReg == '0) && (idxReg == '0);
  assign swapNow       = frameStartNow && pendValidReg;

  // The frame being started already uses the freshly swapped buffer and the
  // updated blink phase, so a zero dead time still never shows a mixed frame.
  assign dispHexCur   = swapNow ? pendHexReg   : dispHexReg;
  assign dispPointCur = swapNow ? pendPointReg : dispPointReg;
  assign dispLeCur    = swapNow ? pendLeReg    : dispLeReg;
  assign dispBlinkCur = swapNow ? pendBlinkReg : dispBlinkReg;
  assign phaseCur     = (frameStartNow && (frameCntReg == FRM_LAST)) ? ~blinkPhaseReg
                                                                     : blinkPhaseReg;

  // Slot counter, digit index, blink frame counter and blink phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slotCntReg    <= '0;
      idxReg        <= '0;
      frameCntReg   <= '0;
      blinkPhaseReg <= 1'b0;
    end else begin
      if (slotWrap) begin
        slotCntReg <= '0;
        idxReg     <= (idxReg == IDX_LAST) ? '0 : idxReg + IDX_W'(1);
      end else begin
        slotCntReg <= slotCntReg + SLOT_W'(1);
      end
      if (frameStartNow) begin
        frameCntReg   <= (frameCntReg == FRM_LAST) ? '0 : frameCntReg + FRM_W'(1);
        blinkPhaseReg <= phaseCur;
      end
    end
  end

  // Double buffer: load fills pending; a frame start moves pending to display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendHexReg   <= '0;
      pendPointReg <= '0;
      pendLeReg    <= '0;
      pendBlinkReg <= '0;
      pendValidReg <= 1'b0;
      dispHexReg   <= '0;
      dispPointReg <= '0;
      dispLeReg    <= '0;
      dispBlinkReg <= '0;
    end else begin
      if (swapNow) begin
        dispHexReg   <= pendHexReg;
        dispPointReg <= pendPointReg;
        dispLeReg    <= pendLeReg;
        dispBlinkReg <= pendBlinkReg;
      end
      if (load) begin
        pendHexReg   <= hexs;
        pendPointReg <= points;
        pendLeReg    <= LEs;
        pendBlinkReg <= blinks;
        pendValidReg <= 1'b1;
      end else if (swapNow) begin
        pendValidReg <= 1'b0;
      end
    end
  end

  // zeroFrom[i] is set when every nibble from the top digit down to i is zero
  always_comb begin
    logic allZero;
    allZero  = 1'b1;
    zeroFrom = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      allZero     = allZero & (dispHexCur[4*i +: 4] == 4'h0);
      zeroFrom[i] = allZero;
    end
  end

  // Per-digit pattern: blank and blink darken everything, suppression only g..a
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : gDigit
    logic darkAll;
    logic suppress;

    assign darkAll = dispLeCur[gi] | (dispBlinkCur[gi] & phaseCur);

    if (gi == 0) begin : gNoSuppress
      assign suppress = 1'b0;
    end else begin : gSuppress
      assign suppress = lz_en & zeroFrom[gi];
    end

    seg_hex_decoder uDecoder (
      .nibble    (dispHexCur[4*gi +: 4]),
      .point     (dispPointCur[gi]),
      .darkSegs  (darkAll | suppress),
      .darkPoint (darkAll),
      .segN      (segPattern[gi])
    );
  end

  // Output registers: all anodes off during the dead window of each slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anReg         <= '1;
      segReg        <= SEG_BLANK;
      frameStartReg <= 1'b0;
    end else begin
      frameStartReg <= frameStartNow;
      if (slotCntReg < DEAD_END) begin
        anReg  <= '1;
        segReg <= SEG_BLANK;
      end else begin
        anReg  <= ~(NUM_DIGITS'(1) << idxReg);
        segReg <= segPattern[idxReg];
      end
    end
  end

  assign AN          = anReg;
  assign SEGMENT     = segReg;
  assign frame_start = frameStartReg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: directed scenarios plus random
// loads, compared every cycle against a frame-level reference model.
module tb_seg_scan_display;

  localparam int N         = 4;
  localparam int SD        = 4;
  localparam int DEAD      = 1;
  localparam int BF        = 2;
  localparam int FRAME_LEN = SD * N;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hexs;
  logic [3:0]  points, LEs, blinks;
  logic        lz_en, load;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // Active-low glyphs including the (off) point bit, digits 0..F.
  logic [7:0] fontN [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state: edges seen since reset release, and both buffers
  int          k;
  logic [15:0] mPendHex, mDispHex;
  logic [3:0]  mPendPt, mDispPt, mPendLe, mDispLe, mPendBl, mDispBl;
  logic        mPv;
  logic [3:0]  expAn;
  logic [7:0]  expSeg;
  logic        expFs;

  seg_scan_display #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (SD),
    .DEAD_CYC     (DEAD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hexs        (hexs),
    .points      (points),
    .LEs         (LEs),
    .blinks      (blinks),
    .lz_en       (lz_en),
    .load        (load),
    .AN          (AN),
    .SEGMENT     (SEGMENT),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic resetModel();
    k        = 0;
    mPendHex = '0; mDispHex = '0;
    mPendPt  = '0; mDispPt  = '0;
    mPendLe  = '0; mDispLe  = '0;
    mPendBl  = '0; mDispBl  = '0;
    mPv      = 1'b0;
  endtask

  // Expected registered outputs for edge k, derived from position arithmetic
  task automatic stepModel();
    int   slot, idx, frame, phase;
    logic [3:0] nib;
    logic [6:0] glyph;
    logic sup;
    slot  = k % SD;
    idx   = (k / SD) % N;
    frame = k / FRAME_LEN;
    phase = ((frame + 1) / BF) % 2;
    expFs = (k % FRAME_LEN) == 0;
    if (expFs && mPv) begin
      mDispHex = mPendHex; mDispPt = mPendPt; mDispLe = mPendLe; mDispBl = mPendBl;
      mPv = 1'b0;
    end
    if (slot < DEAD) begin
      expAn  = 4'hF;
      expSeg = 8'hFF;
    end else begin
      expAn = ~(4'b0001 << idx);
      nib   = mDispHex[4*idx +: 4];
      if (mDispLe[idx] || (mDispBl[idx] && phase == 1)) begin
        expSeg = 8'hFF;
      end else begin
        sup    = lz_en && (idx != 0) && ((mDispHex >> (4*idx)) == 16'h0);
        glyph  = sup ? 7'h7F : fontN[nib][6:0];
        expSeg = {~mDispPt[idx], glyph};
      end
    end
    if (load) begin
      mPendHex = hexs; mPendPt = points; mPendLe = LEs; mPendBl = blinks;
      mPv = 1'b1;
    end
    k++;
  endtask

  task automatic tick();
    @(posedge clk);
    stepModel();
    #1;
    checkVal("AN", 32'(AN), 32'(expAn));
    checkVal("SEGMENT", 32'(SEGMENT), 32'(expSeg));
    checkVal("frame_start", 32'(frame_start), 32'(expFs));
    if (load)
      $display("load k=%0d hexs=%h points=%b LEs=%b blinks=%b lz_en=%b",
               k - 1, hexs, points, LEs, blinks, lz_en);
    load = 1'b0;
  endtask

  // Advance until the next edge to be processed sits at position pos in a frame
  task automatic runTo(input int pos);
    while (k % FRAME_LEN != pos) tick();
  endtask

  task automatic doLoad(input logic [15:0] h, input logic [3:0] p, input logic [3:0] le,
                        input logic [3:0] bl);
    hexs = h; points = p; LEs = le; blinks = bl; load = 1'b1;
    tick();
  endtask

  task automatic randomStim();
    if ($urandom_range(9) == 0) begin
      hexs   = 16'($urandom) >> (4 * $urandom_range(4));
      points = 4'($urandom);
      LEs    = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      blinks = 4'($urandom);
      load   = 1'b1;
    end
    if ($urandom_range(31) == 0) lz_en = ~lz_en;
  endtask

  initial begin
    rst = 1'b1; hexs = '0; points = '0; LEs = '0; blinks = '0; lz_en = 1'b0; load = 1'b0;
    resetModel();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_AN", 32'(AN), 32'h0000_000F);
    checkVal("rst_SEGMENT", 32'(SEGMENT), 32'h0000_00FF);
    checkVal("rst_frame_start", 32'(frame_start), 32'h0);
    rst = 1'b0;

    // Load on the very first (frame-start) edge: frame 0 still shows zeros
    doLoad(16'h1234, 4'h0, 4'h0, 4'h0);
    repeat (16) tick();
    runTo(2);
    checkVal("frame1_digit0_AN", 32'(AN), 32'h0000_000E);
    checkVal("frame1_digit0_SEG", 32'(SEGMENT), 32'h0000_0099);

    // Two loads inside one frame: current frame untouched, last one wins
    runTo(6);
    doLoad(16'hAAAA, 4'h0, 4'h0, 4'h0);
    tick();
    doLoad(16'h5555, 4'h0, 4'h0, 4'h0);
    runTo(0);
    runTo(14);
    checkVal("tear_digit3_SEG", 32'(SEGMENT), 32'h0000_0092);

    // Load exactly on the frame-start edge, with leading-zero suppression
    runTo(0);
    lz_en = 1'b1;
    doLoad(16'h0030, 4'h0, 4'h0, 4'h0);
    repeat (2 * FRAME_LEN) tick();
    doLoad(16'h0030, 4'b1000, 4'h0, 4'h0);
    repeat (2 * FRAME_LEN) tick();

    // Blink on digit 0, then blank on digit 0 overriding blink and point
    lz_en = 1'b0;
    doLoad(16'h0030, 4'h0, 4'h0, 4'b0001);
    repeat (6 * FRAME_LEN) tick();
    doLoad(16'h0030, 4'b0001, 4'b0001, 4'b0001);
    repeat (5 * FRAME_LEN) tick();

    // Random loads and lz_en toggling
    for (int i = 0; i < 2500; i++) begin
      randomStim();
      tick();
    end

    // Asynchronous reset in digit 2's lit window
    runTo(10);
    #2;
    rst = 1'b1;
    #1;
    checkVal("async_rst_AN", 32'(AN), 32'h0000_000F);
    checkVal("async_rst_SEGMENT", 32'(SEGMENT), 32'h0000_00FF);
    checkVal("async_rst_frame_start", 32'(frame_start), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkVal("held_rst_AN", 32'(AN), 32'h0000_000F);
    rst = 1'b0; lz_en = 1'b0; load = 1'b0;
    resetModel();
    repeat (2 * FRAME_LEN) tick();
    for (int i = 0; i < 300; i++) begin
      randomStim();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
